dcache_mem_requester: RTL

Cache-side initiator for the data-cache port of the memory controller. It accepts one miss at a time from the D-cache pipeline. It drives the controller's D request, combining a dirty-victim write-back with the refill read in a single transaction. It then returns the refill line to the cache with a one-cycle valid pulse. It sits between the D-cache tag/data arrays and the memory controller.

---
 rtl/dcache_req_pkg.sv | 16 +
 rtl/dcache_mem_requester_if.sv | 45 ++++
 rtl/dcache_req_watchdog.sv | 42 ++++
 rtl/dcache_mem_requester.sv | 117 +++++++++++
 4 files changed

// File: rtl/dcache_req_pkg.sv
// Shared types and default sizes for the D-cache memory requester.
// Imported by the interface, the watchdog and the top-level requester.
package dcache_req_pkg;

    localparam int DEF_ADDR_W         = 26;
    localparam int DEF_LINE_W         = 128;
    localparam int DEF_TIMEOUT_CYCLES = 64;
    localparam int TMO_CNT_W          = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dcache_mem_requester_if.sv
// Signal bundle between the requester (master) and the D-cache pipeline plus
// memory controller (slave), which the requester faces on either side.
interface dcache_mem_requester_if
    import dcache_req_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
);
    logic              miss_valid;
    logic              miss_ready;
    logic [ADDR_W-1:0] miss_addr;
    logic              victim_dirty;
    logic [ADDR_W-1:0] victim_addr;
    logic [LINE_W-1:0] victim_data;
    logic              refill_valid;
    logic [LINE_W-1:0] refill_data;
    logic [ADDR_W-1:0] refill_addr;
    logic              wb_done;
    logic              busy;
    logic              reqD_cache;
    logic              reqD_cache_write;
    logic [ADDR_W-1:0] reqAddrD_mem;
    logic [ADDR_W-1:0] reqAddrD_write_mem;
    logic [LINE_W-1:0] data_from_cache;
    logic [LINE_W-1:0] data_to_cache;
    logic              read_ready_for_dcache;
    logic              written_data_ack;

    modport master (
        input  miss_valid, miss_addr, victim_dirty, victim_addr, victim_data,
        input  data_to_cache, read_ready_for_dcache, written_data_ack,
        output miss_ready, refill_valid, refill_data, refill_addr, wb_done, busy,
        output reqD_cache, reqD_cache_write, reqAddrD_mem, reqAddrD_write_mem,
        output data_from_cache
    );

    modport slave (
        output miss_valid, miss_addr, victim_dirty, victim_addr, victim_data,
        output data_to_cache, read_ready_for_dcache, written_data_ack,
        input  miss_ready, refill_valid, refill_data, refill_addr, wb_done, busy,
        input  reqD_cache, reqD_cache_write, reqAddrD_mem, reqAddrD_write_mem,
        input  data_from_cache
    );

endinterface

// File: rtl/dcache_req_watchdog.sv
// REQ-state watchdog: cycle counter restarted on every accept, plus a sticky
// error flag raised when the controller never answers within TIMEOUT_CYCLES.
module dcache_req_watchdog
    import dcache_req_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic in_req,
    input  logic ready,
    output logic expire,
    output logic timeout_err
);

    logic [TMO_CNT_W-1:0] count_reg;
    logic                 err_reg;

    // The count equals the number of REQ cycles already elapsed, so expiry
    // on the last permitted cycle gives exactly TIMEOUT_CYCLES REQ cycles.
    assign expire      = in_req && !ready &&
                         (count_reg == TMO_CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (start) begin
                count_reg <= '0;
            end else if (in_req) begin
                count_reg <= count_reg + 1'b1;
            end
            if (expire) begin
                err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_mem_requester.sv
// D-cache miss requester: one outstanding miss, combined write-back + refill
// request to the memory controller. DCACHE_REQ_TIMEOUT_EN adds a REQ watchdog.
module dcache_mem_requester
    import dcache_req_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
`ifdef DCACHE_REQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    dcache_mem_requester_if.master bus
`ifdef DCACHE_REQ_TIMEOUT_EN
    ,
    output logic                  timeout_err
`endif
);

    state_t            state_reg, state_next;
    logic              accept;
    logic              ack_take;
    logic              expire;

    logic [ADDR_W-1:0] addr_reg;
    logic              dirty_reg;
    logic [ADDR_W-1:0] vaddr_reg;
    logic [LINE_W-1:0] vdata_reg;
    logic [LINE_W-1:0] refill_data_reg;
    logic              wb_seen_reg;
    logic              wb_done_reg;

`ifdef DCACHE_REQ_TIMEOUT_EN
    dcache_req_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk         (clk),
        .reset       (reset),
        .start       (accept),
        .in_req      (state_reg == REQ),
        .ready       (bus.read_ready_for_dcache),
        .expire      (expire),
        .timeout_err (timeout_err)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.miss_valid) begin
                    accept     = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus.read_ready_for_dcache) begin
                    state_next = RESP;
                end else if (expire) begin
                    state_next = IDLE;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Only the first acknowledge of a dirty transaction counts as a write-back.
    assign ack_take = (state_reg == REQ) && dirty_reg &&
                      bus.written_data_ack && !wb_seen_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            dirty_reg       <= 1'b0;
            vaddr_reg       <= '0;
            vdata_reg       <= '0;
            refill_data_reg <= '0;
            wb_seen_reg     <= 1'b0;
            wb_done_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wb_done_reg <= ack_take;
            if (accept) begin
                addr_reg    <= bus.miss_addr;
                dirty_reg   <= bus.victim_dirty;
                vaddr_reg   <= bus.victim_addr;
                vdata_reg   <= bus.victim_data;
                wb_seen_reg <= 1'b0;
            end else if (ack_take) begin
                wb_seen_reg <= 1'b1;
            end
            if ((state_reg == REQ) && bus.read_ready_for_dcache) begin
                refill_data_reg <= bus.data_to_cache;
            end
        end
    end

    assign bus.miss_ready         = (state_reg == IDLE);
    assign bus.busy               = (state_reg != IDLE);
    assign bus.reqD_cache         = (state_reg == REQ);
    assign bus.reqD_cache_write   = (state_reg == REQ) && dirty_reg;
    assign bus.reqAddrD_mem       = addr_reg;
    assign bus.reqAddrD_write_mem = vaddr_reg;
    assign bus.data_from_cache    = vdata_reg;
    assign bus.refill_valid       = (state_reg == RESP);
    assign bus.refill_data        = refill_data_reg;
    assign bus.refill_addr        = addr_reg;
    assign bus.wb_done            = wb_done_reg;

endmodule
